// File: rtl/if_prefetch_queue_if.sv
// Prefetch queue bus: instruction-memory req/ack channel plus the IF-facing head view.
// fetch_exc exists only when IFQ_ALIGN_CHECK_EN is defined.
interface if_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
`ifdef IFQ_ALIGN_CHECK_EN
  logic        fetch_exc;
`endif

  // master: the prefetch queue itself; slave: memory + IF stage
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_out,
`ifdef IFQ_ALIGN_CHECK_EN
    output fetch_exc,
`endif
    input  imem_ack, imem_rdata, hold, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_out,
`ifdef IFQ_ALIGN_CHECK_EN
    input  fetch_exc,
`endif
    output imem_ack, imem_rdata, hold, redirect, redirect_pc
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetch FIFO feeding IF; IFQ_ALIGN_CHECK_EN adds misaligned-redirect trap.
// Latency: ack at edge N -> inst_valid from N+1; redirect at N -> empty at N+1.
// Backpressure: hold freezes head; fetch stops once queue plus outstanding fetch reaches DEPTH.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  if_prefetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_dat;
  logic [AW-1:0] rd_ptr, wr_ptr, wr_idx;
  logic [AW:0]   count, count_next;
  logic [1:0]    state, state_d;
  logic [31:0]   fetch_pc, discard_pc;
  logic          halted;
  logic          push, pop, room, wr_en;
  logic [31:0]   redir_pc;
  logic          redir_bad;

`ifdef IFQ_ALIGN_CHECK_EN
  assign redir_pc  = bus.redirect_pc;
  assign redir_bad = |bus.redirect_pc[1:0];
  assign bus.fetch_exc = bus.inst_valid & halted;
`else
  assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};
  assign redir_bad = 1'b0;
`endif

  assign push       = (state == ST_WAIT) & bus.imem_ack & ~bus.redirect;
  assign pop        = bus.inst_valid & ~bus.hold & ~bus.redirect;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  // count_next already includes this cycle's push, so a new request reserves the slot it will fill
  assign room       = count_next < (AW+1)'(DEPTH);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (!halted && room) state_d = ST_WAIT;
      ST_WAIT:    if (bus.imem_ack) state_d = room ? ST_WAIT : ST_IDLE;
      ST_DISCARD: if (bus.imem_ack) state_d = halted ? ST_IDLE : ST_WAIT;
      default:    state_d = ST_IDLE;
    endcase
    if (bus.redirect) begin
      if (state == ST_DISCARD && !bus.imem_ack)
        state_d = ST_DISCARD;
      else if (state == ST_WAIT && !bus.imem_ack)
        state_d = ST_DISCARD;
      else
        state_d = redir_bad ? ST_IDLE : ST_WAIT;
    end
  end

  always_comb begin
    wr_en  = push | (bus.redirect & redir_bad);
    wr_idx = bus.redirect ? '0 : wr_ptr;
    wr_dat = bus.redirect ? '{pc: redir_pc, inst: 32'h0}
                          : '{pc: fetch_pc, inst: bus.imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      discard_pc <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      halted     <= 1'b0;
    end else begin
      state <= state_d;
      if (bus.redirect) begin
        // A misaligned target leaves a single trap entry at slot 0
        rd_ptr   <= '0;
        wr_ptr   <= AW'(redir_bad);
        count    <= (AW+1)'(redir_bad);
        fetch_pc <= redir_pc;
        halted   <= redir_bad;
        if (state == ST_WAIT && !bus.imem_ack) discard_pc <= fetch_pc;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
      end
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.inst_valid = (count != '0);
  assign bus.inst_out   = bus.inst_valid ? head.inst : 32'h0;
  assign bus.pc_out     = bus.inst_valid ? head.pc : fetch_pc;
  assign bus.imem_req   = (state != ST_IDLE);
  assign bus.imem_addr  = (state == ST_DISCARD) ? discard_pc : fetch_pc;
endmodule
